dispatch_queue: RTL



---
 rtl/dispatch_queue.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dispatch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : dispatch_queue
//  Description : Circular fetch-to-dispatch buffer with multi-wide in-order
//                issue, flush and HLT fencing.
//  Revision    : 1.0 - initial release
// ============================================================================
module dispatch_queue #(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 2,
    parameter int INSN_BITS = 32,
    parameter int PC_BITS   = 64
) (
    input  logic                            in_clk,
    input  logic                            in_rst_n,
    input  logic                            in_flush,
    input  logic                            in_fetch_valid,
    input  logic [INSN_BITS-1:0]            in_fetch_insnbits,
    input  logic [PC_BITS-1:0]              in_fetch_pc,
    output logic                            out_fetch_ready,
    output logic [WIDTH-1:0]                out_issue_valid,
    output logic [WIDTH*INSN_BITS-1:0]      out_issue_insnbits,
    output logic [WIDTH*PC_BITS-1:0]        out_issue_pc,
    output logic [WIDTH-1:0]                out_issue_is_halt,
    input  logic [$clog2(WIDTH+1)-1:0]      in_issue_count,
    output logic [$clog2(DEPTH+1)-1:0]      out_count,
    output logic                            out_halted
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH+1);
    localparam int c_ic_w  = $clog2(WIDTH+1);
    localparam logic [INSN_BITS-1:0] c_hlt_mask  = INSN_BITS'(32'hFFE0_001F);
    localparam logic [INSN_BITS-1:0] c_hlt_match = INSN_BITS'(32'hD440_0000);

    logic [INSN_BITS-1:0] r_insn    [DEPTH];
    logic [PC_BITS-1:0]   r_pc      [DEPTH];
    logic [DEPTH-1:0]     r_is_halt;
    logic [c_ptr_w-1:0]   r_head;
    logic [c_ptr_w-1:0]   r_tail;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_halt_pending;
    logic                 r_halted;

    logic [c_ptr_w-1:0]   w_idx [WIDTH];
    logic [WIDTH-1:0]     w_slot_valid;
    logic                 w_blocked;
    logic [c_ic_w-1:0]    w_nvalid;
    logic [c_ic_w-1:0]    w_pop_n;
    logic                 w_pop_halt;
    logic                 w_push;
    logic                 w_is_hlt;

    // Ready depends only on registered state, so a full queue refuses a push
    // even when the same cycle pops.
    assign out_fetch_ready = (r_count < c_cnt_w'(DEPTH)) & ~r_halt_pending;
    assign w_push          = in_fetch_valid & out_fetch_ready;
    assign w_is_hlt        = (in_fetch_insnbits & c_hlt_mask) == c_hlt_match;
    assign out_count       = r_count;
    assign out_halted      = r_halted;

    always_comb begin
        w_blocked          = 1'b0;
        w_nvalid           = '0;
        w_slot_valid       = '0;
        out_issue_insnbits = '0;
        out_issue_pc       = '0;
        out_issue_is_halt  = '0;
        for (int k = 0; k < WIDTH; k++) begin
            w_idx[k]        = r_head + c_ptr_w'(k);
            // A HLT closes the issue window: nothing younger is presented.
            w_slot_valid[k] = (r_count > c_cnt_w'(k)) && !w_blocked;
            w_blocked       = w_blocked | (w_slot_valid[k] & r_is_halt[w_idx[k]]);
            if (w_slot_valid[k]) begin
                w_nvalid = w_nvalid + c_ic_w'(1);
            end
            out_issue_insnbits[k*INSN_BITS +: INSN_BITS] = r_insn[w_idx[k]];
            out_issue_pc[k*PC_BITS +: PC_BITS]           = r_pc[w_idx[k]];
            out_issue_is_halt[k] = w_slot_valid[k] & r_is_halt[w_idx[k]];
        end
    end

    assign out_issue_valid = w_slot_valid;

    always_comb begin
        w_pop_n    = (in_issue_count > w_nvalid) ? w_nvalid : in_issue_count;
        w_pop_halt = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if ((c_ic_w'(k) < w_pop_n) && out_issue_is_halt[k]) begin
                w_pop_halt = 1'b1;
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_halt_pending <= 1'b0;
            r_halted       <= 1'b0;
        end else if (in_flush) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_halt_pending <= 1'b0;
            r_halted       <= 1'b0;
        end else begin
            r_head  <= r_head + c_ptr_w'(w_pop_n);
            r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop_n);
            if (w_push) begin
                r_tail <= r_tail + c_ptr_w'(1);
            end
            if (w_push && w_is_hlt) begin
                r_halt_pending <= 1'b1;
            end else if (w_pop_halt) begin
                r_halt_pending <= 1'b0;
            end
            if (w_pop_halt) begin
                r_halted <= 1'b1;
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_is_halt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_insn[i] <= '0;
                r_pc[i]   <= '0;
            end
        end else if (w_push && !in_flush) begin
            r_insn[r_tail]    <= in_fetch_insnbits;
            r_pc[r_tail]      <= in_fetch_pc;
            r_is_halt[r_tail] <= w_is_hlt;
        end
    end

endmodule
`default_nettype wire
